// File: rtl/spi_slave_rx_pkg.sv
// Shared definitions for the SPI receive slave: frame length, FSM encoding, sync settling.
// Build option: SPI_RX_GLITCH_FILTER_EN adds a 3-tap majority filter on sclk/sync_n.
package spi_slave_rx_pkg;

    localparam int SPI_LEN_DEF = 24;
    localparam int CNT_W_DEF   = 5;

`ifdef SPI_RX_GLITCH_FILTER_EN
    localparam bit GLITCH_FILTER_EN = 1'b1;
    localparam int CLK_SCLK_RATIO   = 6;
    localparam int SETTLE_CYC       = 6;
`else
    localparam bit GLITCH_FILTER_EN = 1'b0;
    localparam int CLK_SCLK_RATIO   = 4;
    localparam int SETTLE_CYC       = 4;
`endif

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2
    } state_t;

endpackage

// File: rtl/spi_slave_rx_if.sv
// SPI wire side plus received-word side of the receive slave, bundled as one interface.
interface spi_slave_rx_if
    import spi_slave_rx_pkg::*;
#(
    parameter int SPI_LEN = SPI_LEN_DEF
);
    logic               sclk;
    logic               din;
    logic               sync_n;
    logic [SPI_LEN-1:0] data_out;
    logic               data_valid;
    logic               frame_err;
    logic               busy;

    modport slave (
        input  sclk, din, sync_n,
        output data_out, data_valid, frame_err, busy
    );

    modport master (
        output sclk, din, sync_n,
        input  data_out, data_valid, frame_err, busy
    );
endinterface

// File: rtl/spi_slave_rx_edge_sync.sv
// Two-flop synchroniser with optional 3-tap majority filter and rise/fall detect.
// Flops reset to 1 so an idle-high line produces no edge on reset release.
module spi_edge_sync #(
    parameter bit FILTER_EN = 1'b0,
    parameter bit EDGE_EN   = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);
    logic r_s1;
    logic r_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    generate
        if (FILTER_EN) begin : g_filt
            logic r_t1;
            logic r_t2;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_t1 <= 1'b1;
                    r_t2 <= 1'b1;
                end else begin
                    r_t1 <= r_s2;
                    r_t2 <= r_t1;
                end
            end

            // Majority is combinational so the filter costs exactly one cycle of latency.
            assign o_q = (r_s2 & r_t1) | (r_s2 & r_t2) | (r_t1 & r_t2);
        end else begin : g_nofilt
            assign o_q = r_s2;
        end

        if (EDGE_EN) begin : g_edge
            logic r_hist;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_hist <= 1'b1;
                else     r_hist <= o_q;
            end

            assign o_rise = ~r_hist &  o_q;
            assign o_fall =  r_hist & ~o_q;
        end else begin : g_noedge
            assign o_rise = 1'b0;
            assign o_fall = 1'b0;
        end
    endgenerate
endmodule

// File: rtl/spi_slave_rx.sv
// SPI receive slave: oversampled sclk/din/sync_n, MSB-first word capture with bit-count check.
// Build option: SPI_RX_GLITCH_FILTER_EN (glitch filter on sclk/sync_n, +1 cycle latency).
//   state     | meaning
//   WAIT_IDLE | after reset, wait for a settled, high sync_n
//   IDLE      | waiting for sync_n fall
//   SHIFT     | shifting bits on sclk fall until sync_n rise
module spi_slave_rx
    import spi_slave_rx_pkg::*;
#(
    parameter int SPI_LEN = SPI_LEN_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_slave_rx_if.slave        bus
);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SPI_LEN);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SPI_LEN + 1);
    localparam logic [2:0]       SETTLE_INIT = 3'(SETTLE_CYC);

    logic w_sclk_lvl_unused, w_sclk_rise_unused, w_sclk_fall;
    logic w_sync_q, w_sync_rise, w_sync_fall;
    logic w_din_q, w_din_rise_unused, w_din_fall_unused;

    spi_edge_sync #(.FILTER_EN(GLITCH_FILTER_EN), .EDGE_EN(1'b1)) u_sync_sclk (
        .clk(clk), .rst(rst), .i_d(bus.sclk),
        .o_q(w_sclk_lvl_unused), .o_rise(w_sclk_rise_unused), .o_fall(w_sclk_fall)
    );

    spi_edge_sync #(.FILTER_EN(GLITCH_FILTER_EN), .EDGE_EN(1'b1)) u_sync_sync (
        .clk(clk), .rst(rst), .i_d(bus.sync_n),
        .o_q(w_sync_q), .o_rise(w_sync_rise), .o_fall(w_sync_fall)
    );

    spi_edge_sync #(.FILTER_EN(1'b0), .EDGE_EN(1'b0)) u_sync_din (
        .clk(clk), .rst(rst), .i_d(bus.din),
        .o_q(w_din_q), .o_rise(w_din_rise_unused), .o_fall(w_din_fall_unused)
    );

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [SPI_LEN-1:0] r_shift, w_shift_nxt;
    logic [SPI_LEN-1:0] r_data, w_data_nxt;
    logic               r_dv, w_dv_nxt;
    logic               r_fe, w_fe_nxt;
    logic [2:0]         r_settle;

    // Reset-preset sync flops read as "idle high" until real line values have flushed through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  r_settle <= SETTLE_INIT;
        else if (r_settle != 3'd0) r_settle <= r_settle - 3'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= WAIT_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_dv    <= 1'b0;
            r_fe    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
            r_data  <= w_data_nxt;
            r_dv    <= w_dv_nxt;
            r_fe    <= w_fe_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_dv_nxt    = 1'b0;
        w_fe_nxt    = 1'b0;
        unique case (r_state)
            WAIT_IDLE: begin
                if (r_settle == 3'd0 && w_sync_q) w_state_nxt = IDLE;
            end
            IDLE: begin
                if (w_sync_fall) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = '0;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (w_sclk_fall) begin
                    w_shift_nxt = {r_shift[SPI_LEN-2:0], w_din_q};
                    if (r_cnt != CNT_SAT) w_cnt_nxt = r_cnt + 1'b1;
                end
                // Checked against the updated count so a coincident final bit is included.
                if (w_sync_rise) begin
                    if (w_cnt_nxt == CNT_FULL) begin
                        w_data_nxt = w_shift_nxt;
                        w_dv_nxt   = 1'b1;
                    end else begin
                        w_fe_nxt   = 1'b1;
                    end
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = WAIT_IDLE;
        endcase
    end

    assign bus.data_out   = r_data;
    assign bus.data_valid = r_dv;
    assign bus.frame_err  = r_fe;
    assign bus.busy       = (r_state == SHIFT);
endmodule

// File: tb/tb_spi_slave_rx.sv
// Scoreboard bench for spi_slave_rx: master-style frames, length errors, reset mid-frame, sclk glitch.
module tb_spi_slave_rx;
    import spi_slave_rx_pkg::*;

    typedef struct {
        bit          is_err;
        logic [23:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_slave_rx_if bus_if ();

    spi_slave_rx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int          n_total = 0;
    int          n_bad   = 0;
    exp_t        sb_q[$];
    logic [23:0] exp_last = 24'h0;
    int          exp_lat;
    int          lat;
    bit          mon_prev = 1'b0;
    exp_t        mon_e;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_ok(input logic [23:0] val);
        exp_t e;
        e.is_err = 1'b0;
        e.data   = val;
        sb_q.push_back(e);
        exp_last = val;
    endtask

    task automatic expect_err();
        exp_t e;
        e.is_err = 1'b1;
        e.data   = exp_last;
        sb_q.push_back(e);
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        bus_if.din = b;
        if (glitch) begin
            tick(1);
            bus_if.sclk = 1'b0;
            tick(1);
            bus_if.sclk = 1'b1;
            tick(2);
        end else begin
            tick(4);
        end
        bus_if.sclk = 1'b0;
        tick(4);
        bus_if.sclk = 1'b1;
    endtask

    task automatic send_frame(input logic [31:0] val, input int nbits, input int glitch_bit,
                              input int gap, input bit chk_busy, output int lat_o);
        bus_if.sync_n = 1'b0;
        tick(4);
        if (chk_busy) check_val("busy_in_frame", bus_if.busy, 1);
        for (int i = nbits - 1; i >= 0; i--) send_bit(val[i], i == glitch_bit);
        tick(2);
        bus_if.sync_n = 1'b1;
        lat_o = 0;
        for (int c = 1; c <= gap; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (lat_o == 0 && (bus_if.data_valid || bus_if.frame_err)) lat_o = c;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus_if.data_valid || bus_if.frame_err) begin
                check_val("excl", {31'b0, bus_if.data_valid & bus_if.frame_err}, 0);
                check_val("pulse_width", {31'b0, mon_prev}, 0);
                if (sb_q.size() == 0) begin
                    check_val("unexpected_pulse", {31'b0, bus_if.frame_err}, 32'hFFFF_FFFF);
                end else begin
                    mon_e = sb_q.pop_front();
                    check_val("kind", {31'b0, bus_if.frame_err}, {31'b0, mon_e.is_err});
                    check_val("data_out", {8'b0, bus_if.data_out}, {8'b0, mon_e.data});
                end
            end
            mon_prev = bus_if.data_valid || bus_if.frame_err;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
        $fatal(1);
    end

    initial begin
`ifdef SPI_RX_GLITCH_FILTER_EN
        exp_lat = 4;
`else
        exp_lat = 3;
`endif
        bus_if.sclk   = 1'b1;
        bus_if.din    = 1'b0;
        bus_if.sync_n = 1'b1;
        tick(3);
        check_val("rst_data_out", {8'b0, bus_if.data_out}, 0);
        check_val("rst_dv", {31'b0, bus_if.data_valid}, 0);
        check_val("rst_fe", {31'b0, bus_if.frame_err}, 0);
        check_val("rst_busy", {31'b0, bus_if.busy}, 0);
        rst = 1'b0;
        tick(10);

        expect_ok(24'hA5F00F);
        send_frame(32'h00A5F00F, 24, -1, 10, 1'b1, lat);
        check_val("lat_first", lat, exp_lat);
        check_val("busy_after", {31'b0, bus_if.busy}, 0);

        expect_ok(24'h000001);
        send_frame(32'h00000001, 24, -1, 2, 1'b0, lat);
        expect_ok(24'hFFFFFE);
        send_frame(32'h00FFFFFE, 24, -1, 10, 1'b0, lat);

        expect_err();
        send_frame(32'h007FFFFF, 23, -1, 10, 1'b0, lat);
        check_val("hold_short", {8'b0, bus_if.data_out}, 32'h00FFFFFE);

        expect_err();
        send_frame(32'h02ABCDEF, 26, -1, 10, 1'b0, lat);
        check_val("hold_long", {8'b0, bus_if.data_out}, 32'h00FFFFFE);
        expect_ok(24'h123456);
        send_frame(32'h00123456, 24, -1, 10, 1'b0, lat);
        check_val("lat_after_long", lat, exp_lat);

        bus_if.sync_n = 1'b0;
        tick(4);
        for (int i = 0; i < 10; i++) send_bit(i[0], 1'b0);
        rst = 1'b1;
        tick(3);
        check_val("midrst_data_out", {8'b0, bus_if.data_out}, 0);
        check_val("midrst_busy", {31'b0, bus_if.busy}, 0);
        exp_last = 24'h0;
        rst = 1'b0;
        for (int i = 0; i < 14; i++) send_bit(~i[0], 1'b0);
        tick(2);
        bus_if.sync_n = 1'b1;
        tick(12);
        check_val("midrst_busy_end", {31'b0, bus_if.busy}, 0);

        expect_ok(24'h654321);
        send_frame(32'h00654321, 24, -1, 10, 1'b1, lat);

`ifdef SPI_RX_GLITCH_FILTER_EN
        expect_ok(24'hC3C3C3);
        send_frame(32'h00C3C3C3, 24, 12, 10, 1'b0, lat);
        check_val("lat_glitch", lat, 4);
`else
        expect_err();
        send_frame(32'h00C3C3C3, 24, 12, 10, 1'b0, lat);
        check_val("hold_glitch", {8'b0, bus_if.data_out}, 32'h00654321);
`endif

        tick(20);
        check_val("sb_drain", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
